program_loader: RTL and testbench

- Writer side of the CPU instruction memory: receives a byte stream over a valid/ready interface and assembles 16-bit instruction words.
- Writes the words sequentially into instruction memory starting at address 0.
- Holds the CPU stalled until a complete, checksum-verified program is resident.
- Sits between a host byte source and the instruction memory write port; the CPU fetch path stays read-only.

---
 rtl/program_loader.sv | 180 ++++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Purpose : turns a byte stream (N, N words high byte first, XOR checksum) into
//           sequential instruction-memory writes from address 0, and holds the CPU
//           until a complete program with a good checksum is resident.
// Latency : one write pulse in the cycle after each LO byte transfer; done/error
//           one cycle after the checksum byte (or the illegal count byte).
// Backpressure: in_ready is high only while receiving (COUNT/HI/LO/CHECK). Any
//           in_valid stall keeps the state, index and checksum unchanged.
// Ports   : clk, rst (sync, active-high); start; in_data/in_valid/in_ready byte
//           stream; imem_write_enable/address/data write port; cpu_hold, busy,
//           done, error status; words_loaded word count.
// ROW_I must not exceed 2**ADDR_WIDTH.
module program_loader #(
  parameter int ROW_I      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_write_enable,
  output logic [ADDR_WIDTH-1:0] imem_write_address,
  output logic [15:0]           imem_write_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  // Doubles as the write index: both are cleared before the first write and
  // advance together on every LO byte.
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         n_q, n_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            hi_q, hi_d;

  logic                  xfer;
  logic                  cnt_bad;

  // in_ready_q mirrors "state is a receiving state", so xfer is exactly the handshake.
  assign xfer    = in_valid & rdy_q;
  assign cnt_bad = (in_data == 8'd0) || ({1'b0, in_data} > 9'(ROW_I));

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    csum_d  = csum_q;
    hi_d    = hi_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_COUNT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (cnt_bad) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_HI;
            n_d     = CW'(in_data);
            csum_d  = in_data;
            cnt_d   = '0;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          state_d = S_LO;
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
        end
      end
      S_LO: begin
        if (xfer) begin
          csum_d  = csum_q ^ in_data;
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = {hi_q, in_data};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q + CW'(1) == n_q) ? S_CHECK : S_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_COUNT) || (state_d == S_HI) ||
            (state_d == S_LO)    || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
    end
  end

  assign in_ready           = rdy_q;
  assign imem_write_enable  = we_q;
  assign imem_write_address = addr_q;
  assign imem_write_data    = wdata_q;
  assign cpu_hold           = hold_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = err_q;
  assign words_loaded       = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Purpose : exercises program_loader with directed and random byte streams.
// Latency : n/a (bench).
// Backpressure: bench drives in_valid with random or fixed stall gaps.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_write_enable;
  logic [3:0]  imem_write_address;
  logic [15:0] imem_write_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [19:0] obs_writes[$];
  logic [19:0] exp_writes[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_words;

  program_loader #(.ROW_I(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_write_enable(imem_write_enable),
    .imem_write_address(imem_write_address), .imem_write_data(imem_write_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every cycle the strobe is high is one write.
  always @(negedge clk) begin
    if (imem_write_enable) obs_writes.push_back({imem_write_address, imem_write_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what a stream should produce, from the stream-format rules only.
  task automatic model_load(input logic [7:0] q[$]);
    int n;
    logic [7:0] cs;
    exp_writes.delete();
    n = int'(q[0]);
    if (n == 0 || n > 16) begin
      exp_done  = 1'b0;
      exp_err   = 1'b1;
      exp_words = 0;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i <= 2 * n; i++) cs = cs ^ q[i];
    for (int w = 0; w < n; w++) exp_writes.push_back({4'(w), q[1 + 2 * w], q[2 + 2 * w]});
    exp_words = n;
    exp_done  = (cs == q[2 * n + 1]);
    exp_err   = !exp_done;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int waited;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("rdy_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Sends q[from..to-1]; after each LO byte the write must already be visible.
  task automatic send_range(input logic [7:0] q[$], input int from, input int to,
                            input int smin, input int smax);
    int n;
    n = int'(q[0]);
    for (int i = from; i < to; i++) begin
      send_byte(q[i], int'($urandom_range(smax, smin)));
      if (n >= 1 && n <= 16 && i >= 2 && i <= 2 * n && (i % 2) == 0) begin
        check("lo_we", 32'(imem_write_enable), 32'd1);
        check("lo_wr", 32'({imem_write_address, imem_write_data}),
              32'({4'(i / 2 - 1), q[i - 1], q[i]}));
      end
    end
  endtask

  task automatic check_result(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_nwr"}, 32'(obs_writes.size()), 32'(exp_writes.size()));
    for (int i = 0; i < exp_writes.size() && i < obs_writes.size(); i++)
      check({tag, "_wr"}, 32'(obs_writes[i]), 32'(exp_writes[i]));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(error), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
  endtask

  task automatic run_load(input string tag, input logic [7:0] q[$], input int smin,
                          input int smax);
    model_load(q);
    obs_writes.delete();
    pulse_start();
    send_range(q, 0, q.size(), smin, smax);
    check_result(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_write_enable), 32'd0);
    check({tag, "_wr"}, 32'({imem_write_address, imem_write_data}), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_stat"}, 32'({busy, done, error}), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Offer bytes where the loader must not take them; nothing may change.
  task automatic offer_idle(input string tag);
    logic [4:0] w0;
    logic       d0;
    w0 = words_loaded;
    d0 = done;
    obs_writes.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, "_words"}, 32'(words_loaded), 32'(w0));
    check({tag, "_done"}, 32'(done), 32'(d0));
    check({tag, "_nwr"}, 32'(obs_writes.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] cs;
    int n;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    offer_idle("idle");

    q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_load("good", q, 0, 0);
    offer_idle("in_done");

    q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    run_load("badcs", q, 0, 0);
    q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_load("recover", q, 0, 1);

    q = '{8'h00};
    run_load("cnt0", q, 0, 0);
    q = '{8'h11};
    run_load("cnt17", q, 0, 0);

    q = '{8'h10};
    cs = 8'h10;
    for (int i = 0; i < 32; i++) begin
      q.push_back(8'($urandom));
      cs = cs ^ q[q.size() - 1];
    end
    q.push_back(cs);
    run_load("full16", q, 0, 0);

    q = '{8'h01, 8'hFF, 8'h00, 8'hFE};
    run_load("stall", q, 3, 3);

    // start after the HI byte of word 0 must be ignored
    q = '{8'h02, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h00};
    q[5] = q[0] ^ q[1] ^ q[2] ^ q[3] ^ q[4];
    model_load(q);
    obs_writes.delete();
    pulse_start();
    send_range(q, 0, 2, 0, 0);
    pulse_start();
    send_range(q, 2, q.size(), 0, 0);
    check_result("midstart");

    // reset after one of three words
    q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
    q[7] = q[0] ^ q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5] ^ q[6];
    obs_writes.delete();
    pulse_start();
    send_range(q, 0, 3, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    check("midrst_nwr", 32'(obs_writes.size()), 32'd1);
    if (obs_writes.size() > 0) check("midrst_wr", 32'(obs_writes[0]), 32'h01122);
    rst = 1'b0;
    @(negedge clk);
    run_load("after_rst", q, 0, 1);

    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(16, 1));
      q = '{8'(n)};
      cs = 8'(n);
      for (int i = 0; i < 2 * n; i++) begin
        q.push_back(8'($urandom));
        cs = cs ^ q[q.size() - 1];
      end
      if ($urandom_range(3, 0) == 0) cs = cs ^ (8'h01 << $urandom_range(7, 0));
      q.push_back(cs);
      run_load("rand", q, 0, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
